// File: rtl/dispatch_ctrl.sv
// Issue-queue dispatch controller: buffers decoded instructions in order and
// hands the oldest one to the ROB plus either the RS or the LSB.
module dispatch_ctrl #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 3,
    parameter int OP_LD = 3,
    parameter int OP_ST = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            dc_valid,
    input  logic [OP_W-1:0] dc_opType,
    input  logic [31:0]     dc_rs1,
    input  logic [31:0]     dc_rs2,
    input  logic [4:0]      dc_rd,
    input  logic [31:0]     dc_imm,
    input  logic [31:0]     dc_PC,
    output logic            if_stall,
    input  logic            rob_full,
    input  logic            rs_full,
    input  logic            lsb_full,
    input  logic            rob_clear,
    output logic            iss_rob_valid,
    output logic            iss_rs_valid,
    output logic            iss_lsb_valid,
    output logic [OP_W-1:0] iss_opType,
    output logic [31:0]     iss_rs1,
    output logic [31:0]     iss_rs2,
    output logic [4:0]      iss_rd,
    output logic [31:0]     iss_imm,
    output logic [31:0]     iss_PC,
    output logic            overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [OP_W-1:0] LD_C = OP_W'(OP_LD);
    localparam logic [OP_W-1:0] ST_C = OP_W'(OP_ST);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 1);

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [31:0]     rs1;
        logic [31:0]     rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [31:0]     pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        iss_q, iss_d;
    entry_t        head_e, in_e;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          rob_v_q, rob_v_d;
    logic          rs_v_q, rs_v_d;
    logic          lsb_v_q, lsb_v_d;
    logic          stall_q, stall_d;
    logic          ovf_q, ovf_d;
    logic          head_lsb, deq, enq, full, wr_en;

    always_comb begin
        in_e = '{op: dc_opType, rs1: dc_rs1, rs2: dc_rs2,
                 rd: dc_rd, imm: dc_imm, pc: dc_PC};
        head_e   = mem_q[head_q];
        head_lsb = (head_e.op == LD_C) || (head_e.op == ST_C);
        full     = (count_q == FULL_C);
        deq      = (count_q != '0) && !rob_full &&
                   (head_lsb ? !lsb_full : !rs_full);
        enq      = dc_valid && (!full || deq);
        wr_en    = enq && !rob_clear;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        iss_d   = iss_q;
        rob_v_d = 1'b0;
        rs_v_d  = 1'b0;
        lsb_v_d = 1'b0;
        stall_d = stall_q;
        ovf_d   = ovf_q;

        if (rob_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            stall_d = 1'b0;
        end else begin
            if (deq) begin
                head_d  = head_q + PW'(1);
                iss_d   = head_e;
                rob_v_d = 1'b1;
                lsb_v_d = head_lsb;
                rs_v_d  = !head_lsb;
            end
            if (enq)
                tail_d = tail_q + PW'(1);
            // A full queue only drops the offer when nothing leaves this edge
            if (dc_valid && full && !deq)
                ovf_d = 1'b1;
            if (enq && !deq)
                count_d = count_q + CW'(1);
            else if (!enq && deq)
                count_d = count_q - CW'(1);
            stall_d = (count_d >= STALL_C);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && wr_en)
            mem_q[tail_q] <= in_e;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            iss_q   <= '0;
            rob_v_q <= 1'b0;
            rs_v_q  <= 1'b0;
            lsb_v_q <= 1'b0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            iss_q   <= iss_d;
            rob_v_q <= rob_v_d;
            rs_v_q  <= rs_v_d;
            lsb_v_q <= lsb_v_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
        end
    end

    assign if_stall      = stall_q;
    assign overflow      = ovf_q;
    assign iss_rob_valid = rob_v_q;
    assign iss_rs_valid  = rs_v_q;
    assign iss_lsb_valid = lsb_v_q;
    assign iss_opType    = iss_q.op;
    assign iss_rs1       = iss_q.rs1;
    assign iss_rs2       = iss_q.rs2;
    assign iss_rd        = iss_q.rd;
    assign iss_imm       = iss_q.imm;
    assign iss_PC        = iss_q.pc;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: reset, routing, ordering, backpressure,
// overflow, flush and freeze, with hand-computed expectations.
module tb_dispatch_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, dc_valid;
    logic [2:0]  dc_opType;
    logic [31:0] dc_rs1, dc_rs2, dc_imm, dc_PC;
    logic [4:0]  dc_rd;
    logic        if_stall, rob_full, rs_full, lsb_full, rob_clear;
    logic        iss_rob_valid, iss_rs_valid, iss_lsb_valid;
    logic [2:0]  iss_opType;
    logic [31:0] iss_rs1, iss_rs2, iss_imm, iss_PC;
    logic [4:0]  iss_rd;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    dispatch_ctrl #(.DEPTH(4), .OP_W(3), .OP_LD(3), .OP_ST(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dc_valid(dc_valid), .dc_opType(dc_opType),
        .dc_rs1(dc_rs1), .dc_rs2(dc_rs2), .dc_rd(dc_rd),
        .dc_imm(dc_imm), .dc_PC(dc_PC), .if_stall(if_stall),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_clear(rob_clear), .iss_rob_valid(iss_rob_valid),
        .iss_rs_valid(iss_rs_valid), .iss_lsb_valid(iss_lsb_valid),
        .iss_opType(iss_opType), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_imm(iss_imm), .iss_PC(iss_PC),
        .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // checks the three valid pulses as a 3-bit {rob,rs,lsb} vector
    task automatic chk_v(input string tag, input logic [2:0] exp);
        chk(tag, 32'({iss_rob_valid, iss_rs_valid, iss_lsb_valid}),
            32'(exp));
    endtask

    task automatic offer(input logic [2:0] op, input logic [31:0] pc);
        dc_valid  = 1'b1;
        dc_opType = op;
        dc_PC     = pc;
        dc_rs1    = pc + 32'h1000;
        dc_rs2    = pc + 32'h2000;
        dc_imm    = pc + 32'h3000;
        dc_rd     = pc[6:2];
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        offer(3'd1, 32'h50);

        // reset held two cycles with an offer present
        tick(); tick();
        chk_v("rst_valids", 3'b000);
        chk("rst_stall", 32'(if_stall), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_pc", iss_PC, 32'h0);
        rst_in = 1'b0; dc_valid = 1'b0;
        tick(); tick();
        chk_v("rst_nodisp", 3'b000);

        // single RS op, two-edge latency
        offer(3'd1, 32'h100);
        tick();
        dc_valid = 1'b0;
        chk_v("rs_nobypass", 3'b000);
        tick();
        chk_v("rs_disp", 3'b110);
        chk("rs_pc", iss_PC, 32'h100);
        chk("rs_rd", 32'(iss_rd), 32'h0);
        chk("rs_imm", iss_imm, 32'h3100);
        tick();
        chk_v("rs_pulse", 3'b000);
        chk("rs_pchold", iss_PC, 32'h100);

        // LD blocked by lsb_full holds back younger ADD
        lsb_full = 1'b1;
        offer(3'd3, 32'h0); tick();
        offer(3'd1, 32'h4); tick();
        dc_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_v("blk_none", 3'b000);
            tick();
        end
        chk("blk_stall", 32'(if_stall), 32'd0);
        lsb_full = 1'b0;
        tick();
        chk_v("ord_ld", 3'b101);
        chk("ord_ld_pc", iss_PC, 32'h0);
        tick();
        chk_v("ord_add", 3'b110);
        chk("ord_add_pc", iss_PC, 32'h4);
        tick();
        chk_v("ord_end", 3'b000);

        // backpressure, stall threshold and overflow
        rob_full = 1'b1;
        offer(3'd1, 32'h10); tick();
        chk("bp_stall1", 32'(if_stall), 32'd0);
        offer(3'd3, 32'h14); tick();
        chk("bp_stall2", 32'(if_stall), 32'd0);
        offer(3'd1, 32'h18); tick();
        chk("bp_stall3", 32'(if_stall), 32'd1);
        offer(3'd4, 32'h1c); tick();
        chk("bp_ovf0", 32'(overflow), 32'd0);
        offer(3'd1, 32'h20); tick();
        chk("bp_ovf1", 32'(overflow), 32'd1);
        chk_v("bp_none", 3'b000);
        dc_valid = 1'b0; rob_full = 1'b0;
        tick();
        chk_v("dr0_v", 3'b110);
        chk("dr0_pc", iss_PC, 32'h10);
        chk("dr0_stall", 32'(if_stall), 32'd1);
        tick();
        chk_v("dr1_v", 3'b101);
        chk("dr1_pc", iss_PC, 32'h14);
        chk("dr1_stall", 32'(if_stall), 32'd0);
        tick();
        chk_v("dr2_v", 3'b110);
        chk("dr2_pc", iss_PC, 32'h18);
        tick();
        chk_v("dr3_v", 3'b101);
        chk("dr3_pc", iss_PC, 32'h1c);
        chk("dr3_op", 32'(iss_opType), 32'd4);
        tick();
        chk_v("dr_end", 3'b000);

        // flush with a same-cycle offer
        rob_full = 1'b1;
        offer(3'd1, 32'h30); tick();
        offer(3'd1, 32'h34); tick();
        offer(3'd1, 32'h38); tick();
        chk("fl_stall_pre", 32'(if_stall), 32'd1);
        rob_clear = 1'b1;
        offer(3'd1, 32'h3c); tick();
        rob_clear = 1'b0; dc_valid = 1'b0; rob_full = 1'b0;
        chk_v("fl_v", 3'b000);
        chk("fl_stall", 32'(if_stall), 32'd0);
        chk("fl_ovf_kept", 32'(overflow), 32'd1);
        tick();
        chk_v("fl_empty", 3'b000);
        offer(3'd1, 32'h200); tick();
        dc_valid = 1'b0;
        tick();
        chk_v("fl_after", 3'b110);
        chk("fl_after_pc", iss_PC, 32'h200);

        // freeze mid-stream
        offer(3'd1, 32'h300); tick();
        offer(3'd3, 32'h304); tick();
        chk_v("fz_a", 3'b110);
        chk("fz_a_pc", iss_PC, 32'h300);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) dc_valid = 1'b0;
            else offer(3'd1, 32'h999);
            tick();
            chk_v("fz_hold_v", 3'b110);
            chk("fz_hold_pc", iss_PC, 32'h300);
        end
        rdy_in = 1'b1; dc_valid = 1'b0;
        tick();
        chk_v("fz_b", 3'b101);
        chk("fz_b_pc", iss_PC, 32'h304);
        tick();
        chk_v("fz_end", 3'b000);

        // reset mid-operation discards queued entries and overflow
        rob_full = 1'b1;
        offer(3'd1, 32'h400); tick();
        offer(3'd1, 32'h404); tick();
        dc_valid = 1'b0;
        rst_in = 1'b1; tick();
        rst_in = 1'b0; rob_full = 1'b0;
        chk("rr_ovf", 32'(overflow), 32'd0);
        tick(); tick();
        chk_v("rr_none", 3'b000);
        chk("rr_pc", iss_PC, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sequences decoded instructions from the decoder into the ROB plus either the reservation station (RS) or the load/store buffer (LSB).
- Sits between the decoder issue outputs and the ROB/RS/LSB issue inputs.
- Buffers decoder output in a small in-order queue and holds IF via a stall signal when downstream is full.
- Clears everything on a ROB flush (mispredict).

Parameters:
DEPTH, 4, issue queue entries (power of two, >=2)
OP_W, 3, width of opType field
OP_LD, 3, opType code routed to LSB (load)
OP_ST, 4, opType code routed to LSB (store); all other codes route to RS

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; low = freeze all state
dc_valid  input  1  decoder issue_ready; one instruction offered this cycle
dc_opType  input  OP_W  decoded op class
dc_rs1  input  32  rs1 value/tag
dc_rs2  input  32  rs2 value/tag
dc_rd  input  5  destination register
dc_imm  input  32  immediate
dc_PC  input  32  instruction PC
if_stall  output  1  IF must not present a new instruction next cycle
rob_full  input  1  ROB cannot accept
rs_full  input  1  RS cannot accept
lsb_full  input  1  LSB cannot accept
rob_clear  input  1  flush (mispredict)
iss_rob_valid  output  1  ROB allocate pulse
iss_rs_valid  output  1  RS issue pulse
iss_lsb_valid  output  1  LSB issue pulse
iss_opType  output  OP_W  payload
iss_rs1  output  32  payload
iss_rs2  output  32  payload
iss_rd  output  5  payload
iss_imm  output  32  payload
iss_PC  output  32  payload
overflow  output  1  sticky error: enqueue attempted while full

Behaviour:
- Reset (rst_in high at posedge): head=tail=count=0.
  - All iss_* valids 0; payload outputs 0; if_stall 0; overflow 0.
  - Reset mid-operation discards queue contents.
- rdy_in low, rst_in low: no state or output register changes. Valid pulses hold their previous value; downstream must also gate on rdy_in.
- Priority per edge: rst_in > rdy_in low (freeze) > rob_clear > normal.
- rob_clear: queue emptied (head=tail=count=0), all iss_* valids 0, overflow unchanged. A dc_valid arriving in the same cycle is discarded.
- Enqueue: dc_valid high at an edge → payload written at tail; tail wraps modulo DEPTH; count+1.
- Full condition: dc_valid with count==DEPTH and no same-cycle dequeue → entry dropped, overflow set (sticky until reset).
- Dequeue condition at an edge: count>0 AND !rob_full AND target unit not full.
  - Target unit is LSB if head opType is OP_LD or OP_ST, else RS.
  - Exactly one dequeue per cycle max. Strictly in order: a blocked head blocks all younger entries.
- Dispatch outputs are registered.
  - On the dequeue edge: payload registers load the head entry; iss_rob_valid=1; iss_lsb_valid=1 if LSB target, else iss_rs_valid=1.
  - On any edge without dequeue: all valids 0 (single-cycle pulses), payload holds.
- Simultaneous enqueue and dequeue: count unchanged; allowed when full (dequeue frees the slot first).
- Empty queue with dc_valid: no bypass. Earliest dispatch is the edge after the enqueue edge, so valid is seen one cycle after that (2-edge latency).
- if_stall (registered) = next count >= DEPTH-1. This leaves one slot for the instruction already in flight from IF/decoder. Cleared by rob_clear and reset.
- count width = log2(DEPTH)+1. Pointers are log2(DEPTH) bits with natural wrap.

Test Plan:
- Reset: hold rst_in 2 cycles with dc_valid=1 → all valids 0, if_stall 0, overflow 0, nothing dispatched after release.
- Single RS op: dc_valid 1 cycle, opType=1, PC=0x100, all fulls 0 → two edges later iss_rob_valid=iss_rs_valid=1 for one cycle, iss_PC=0x100, iss_lsb_valid=0.
- Routing and in-order: enqueue LD(3) PC=0x0, then ADD(1) PC=0x4 with lsb_full=1 for 5 cycles → nothing dispatched while blocked. After release: LD on LSB, then ADD on RS on consecutive cycles.
- Backpressure: rob_full=1, feed 3 ops → if_stall asserts once count reaches 3. A 5th enqueue with count=4 sets overflow=1 and is dropped. After rob_full=0, exactly 4 ops drain in order.
- Flush: 3 entries queued, rob_clear 1 cycle with dc_valid=1 → no valids afterwards, if_stall 0, subsequent op PC=0x200 dispatches normally.
- Freeze: rdy_in=0 for 3 cycles mid-stream with dc_valid pulsing → queue count, pointers and outputs unchanged. Resume dispatch order is identical to the run without freeze.
